// File: rtl/btn_sw_conditioner_pkg.sv
// Shared definitions for the button/switch input conditioner: debounce FSM
// state encoding, button channel indices and the default debounce window.
package btn_sw_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_DEFAULT = 1000000;

endpackage : btn_sw_conditioner_pkg

// File: rtl/btn_debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce counter, press/release FSM
// and a registered single-cycle pulse on each accepted press.
module btn_debounce_channel
    import btn_sw_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_bit;
    btn_state_t       state;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_bit  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_bit  <= sync_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
        end
    end

    // The counter only advances while the synchronised level disagrees with
    // the accepted level; a relapse drops straight back without any pulse.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sync_bit) begin
                    state_next = PRESS_CHK;
                    cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync_bit) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync_bit) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = '0;
                end
            end
            RELEASE_CHK: begin
                if (sync_bit) begin
                    state_next = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Only a completed press qualification fires; HELD re-entered from
    // RELEASE_CHK is a release bounce and stays silent.
    assign pulse_next = (state == PRESS_CHK) && (state_next == HELD);

    assign level = (state == HELD) || (state == RELEASE_CHK);

endmodule : btn_debounce_channel

// File: rtl/btn_sw_conditioner.sv
// Input stage for the EX operand/opcode latch: debounced one-shot button
// strobes plus synchronised (not debounced) slide switches.
module btn_sw_conditioner
    import btn_sw_conditioner_pkg::*;
#(
    parameter int NB_BTN          = 3,
    parameter int NB_SW           = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NB_BTN-1:0] i_btn,
    input  logic [NB_SW-1:0]  i_sw,
    output logic [NB_BTN-1:0] o_btn_pulse,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_SW-1:0]  o_sw
);

    logic [NB_SW-1:0] sw_meta;

    for (genvar g = 0; g < NB_BTN; g++) begin : g_channel
        btn_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clock(clock),
            .reset(reset),
            .raw  (i_btn[g]),
            .pulse(o_btn_pulse[g]),
            .level(o_btn_level[g])
        );
    end

    // Switches are only synchronised; the operator keeps them still for the
    // whole debounce window, so they are settled by the time a pulse fires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            o_sw    <= '0;
        end else begin
            sw_meta <= i_sw;
            o_sw    <= sw_meta;
        end
    end

endmodule : btn_sw_conditioner

// File: tb/tb_btn_sw_conditioner.sv
// Directed self-checking bench for btn_sw_conditioner with a 4-cycle
// debounce window; expected values are hand-derived edge counts.
module tb_btn_sw_conditioner;

    localparam logic [15:0] SW_VAL = 16'h0020;

    logic        clock;
    logic        reset;
    logic [2:0]  i_btn;
    logic [15:0] i_sw;
    logic [2:0]  o_btn_pulse;
    logic [2:0]  o_btn_level;
    logic [15:0] o_sw;

    int check_count = 0;
    int fail_count  = 0;

    btn_sw_conditioner #(
        .NB_BTN         (3),
        .NB_SW          (16),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .i_btn      (i_btn),
        .i_sw       (i_sw),
        .o_btn_pulse(o_btn_pulse),
        .o_btn_level(o_btn_level),
        .o_sw       (o_sw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] btn, input logic [15:0] sw);
        i_btn = btn;
        i_sw  = sw;
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    // Drop all buttons and let every channel settle back to IDLE.
    task automatic releaseAll(input string tag);
        applyStimulus(3'b000, SW_VAL);
        for (int k = 0; k < 10; k++) begin
            advance();
            checkOutput($sformatf("%s_rel_pulse_%0d", tag, k), 32'(o_btn_pulse), 32'(3'b000));
        end
        checkOutput({tag, "_rel_level"}, 32'(o_btn_level), 32'(3'b000));
    endtask

    initial begin
        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(3'b000, 16'h0000);
        repeat (3) advance();
        checkOutput("reset_pulse", 32'(o_btn_pulse), 32'(3'b000));
        checkOutput("reset_level", 32'(o_btn_level), 32'(3'b000));
        checkOutput("reset_sw", 32'(o_sw), 32'(16'h0000));
        reset = 1'b0;
        repeat (2) advance();

        // 1: clean press of A with switch value, then release
        applyStimulus(3'b001, SW_VAL);
        for (int k = 0; k < 20; k++) begin
            advance();
            checkOutput($sformatf("t1_pulse_%0d", k), 32'(o_btn_pulse),
                        32'((k == 6) ? 3'b001 : 3'b000));
            checkOutput($sformatf("t1_level_%0d", k), 32'(o_btn_level),
                        32'((k >= 6) ? 3'b001 : 3'b000));
            checkOutput($sformatf("t1_sw_%0d", k), 32'(o_sw),
                        32'((k >= 1) ? SW_VAL : 16'h0000));
        end
        applyStimulus(3'b000, SW_VAL);
        for (int k = 0; k < 10; k++) begin
            advance();
            checkOutput($sformatf("t1r_level_%0d", k), 32'(o_btn_level),
                        32'((k >= 6) ? 3'b000 : 3'b001));
            checkOutput($sformatf("t1r_pulse_%0d", k), 32'(o_btn_pulse), 32'(3'b000));
        end

        // 2: 3-cycle glitch on B
        for (int k = 0; k < 14; k++) begin
            applyStimulus((k < 3) ? 3'b010 : 3'b000, SW_VAL);
            advance();
            checkOutput($sformatf("t2_pulse_%0d", k), 32'(o_btn_pulse), 32'(3'b000));
            checkOutput($sformatf("t2_level_%0d", k), 32'(o_btn_level), 32'(3'b000));
        end

        // 3: bounce 1,0,1,0 then stable high on A; last rise sampled at edge 4
        for (int k = 0; k < 20; k++) begin
            applyStimulus((k == 1 || k == 3) ? 3'b000 : 3'b001, SW_VAL);
            advance();
            checkOutput($sformatf("t3_pulse_%0d", k), 32'(o_btn_pulse),
                        32'((k == 10) ? 3'b001 : 3'b000));
            checkOutput($sformatf("t3_level_%0d", k), 32'(o_btn_level),
                        32'((k >= 10) ? 3'b001 : 3'b000));
        end
        releaseAll("t3");

        // 4: A and OP pressed together
        applyStimulus(3'b101, SW_VAL);
        for (int k = 0; k < 12; k++) begin
            advance();
            checkOutput($sformatf("t4_pulse_%0d", k), 32'(o_btn_pulse),
                        32'((k == 6) ? 3'b101 : 3'b000));
            checkOutput($sformatf("t4_level_%0d", k), 32'(o_btn_level),
                        32'((k >= 6) ? 3'b101 : 3'b000));
        end
        releaseAll("t4");

        // 5: OP held, released with a 2-cycle relapse, then pressed again
        applyStimulus(3'b100, SW_VAL);
        for (int k = 0; k < 10; k++) begin
            advance();
            checkOutput($sformatf("t5a_pulse_%0d", k), 32'(o_btn_pulse),
                        32'((k == 6) ? 3'b100 : 3'b000));
        end
        for (int k = 0; k < 15; k++) begin
            applyStimulus((k == 1 || k == 2) ? 3'b100 : 3'b000, SW_VAL);
            advance();
            checkOutput($sformatf("t5b_pulse_%0d", k), 32'(o_btn_pulse), 32'(3'b000));
            checkOutput($sformatf("t5b_level_%0d", k), 32'(o_btn_level),
                        32'((k < 9) ? 3'b100 : 3'b000));
        end
        applyStimulus(3'b100, SW_VAL);
        for (int k = 0; k < 10; k++) begin
            advance();
            checkOutput($sformatf("t5c_pulse_%0d", k), 32'(o_btn_pulse),
                        32'((k == 6) ? 3'b100 : 3'b000));
        end
        releaseAll("t5");

        // 6: reset asserted mid-qualification on A with the button held
        applyStimulus(3'b001, SW_VAL);
        repeat (4) advance();
        checkOutput("t6_pre_sw", 32'(o_sw), 32'(SW_VAL));
        reset = 1'b1;
        #1;
        checkOutput("t6_async_sw", 32'(o_sw), 32'(16'h0000));
        checkOutput("t6_async_pulse", 32'(o_btn_pulse), 32'(3'b000));
        checkOutput("t6_async_level", 32'(o_btn_level), 32'(3'b000));
        for (int k = 0; k < 6; k++) begin
            advance();
            checkOutput($sformatf("t6_rst_pulse_%0d", k), 32'(o_btn_pulse), 32'(3'b000));
            checkOutput($sformatf("t6_rst_level_%0d", k), 32'(o_btn_level), 32'(3'b000));
            checkOutput($sformatf("t6_rst_sw_%0d", k), 32'(o_sw), 32'(16'h0000));
        end
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            advance();
            checkOutput($sformatf("t6_pulse_%0d", k), 32'(o_btn_pulse),
                        32'((k == 6) ? 3'b001 : 3'b000));
            checkOutput($sformatf("t6_level_%0d", k), 32'(o_btn_level),
                        32'((k >= 6) ? 3'b001 : 3'b000));
            checkOutput($sformatf("t6_sw_%0d", k), 32'(o_sw),
                        32'((k >= 1) ? SW_VAL : 16'h0000));
        end
        releaseAll("t6");

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule : tb_btn_sw_conditioner
